// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit feeding HI/LO.
// Define MULTDIV_DIV_EN to build the divide path; otherwise div requests end as div_zero.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [WIDTH:0]   mcand_q, mcand_d, acc_hi_q, acc_hi_d, sum;
    logic [WIDTH-1:0]        acc_lo_q, acc_lo_d, hi_q, hi_d, lo_q, lo_d;
    logic                    qm1_q, qm1_d, dz_q, dz_d;
    logic                    last;
`ifdef MULTDIV_DIV_EN
    logic [WIDTH-1:0]        dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d;
    logic                    nq_q, nq_d, nr_q, nr_d;
    logic [WIDTH:0]          rsh, diff;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction
`endif

    assign last     = (cnt_q == CW'(WIDTH - 1));
    assign busy     = (state_q == MULT) || (state_q == DIV) || (state_q == FIX);
    assign done     = (state_q == DONE);
    assign div_zero = done && dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        qm1_d    = qm1_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sum      = acc_hi_q;
`ifdef MULTDIV_DIV_EN
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        nq_d     = nq_q;
        nr_d     = nr_q;
        rsh      = {rem_q, quo_q[WIDTH-1]};
        diff     = rsh - {1'b0, dvs_q};
`endif
        // Booth recoding of {q0, q-1}; the extra accumulator bit absorbs -(-2^(W-1))
        case ({acc_lo_q[0], qm1_q})
            2'b01:   sum = acc_hi_q + mcand_q;
            2'b10:   sum = acc_hi_q - mcand_q;
            default: sum = acc_hi_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    dz_d  = 1'b0;
                    if (!op) begin
                        mcand_d  = {a[WIDTH-1], a};
                        acc_hi_d = '0;
                        acc_lo_d = b;
                        qm1_d    = 1'b0;
                        state_d  = MULT;
`ifdef MULTDIV_DIV_EN
                    end else if (b == '0) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        dvs_d   = mag(b);
                        quo_d   = mag(a);
                        rem_d   = '0;
                        nq_d    = a[WIDTH-1] ^ b[WIDTH-1];
                        nr_d    = a[WIDTH-1];
                        state_d = DIV;
                    end
`else
                    end else begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            MULT: begin
                acc_hi_d = sum >>> 1;
                acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
                qm1_d    = acc_lo_q[0];
                cnt_d    = cnt_q + CW'(1);
                if (last) begin
                    hi_d    = acc_hi_d[WIDTH-1:0];
                    lo_d    = acc_lo_d;
                    state_d = DONE;
                end
            end
`ifdef MULTDIV_DIV_EN
            DIV: begin
                cnt_d = cnt_q + CW'(1);
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rsh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (last) state_d = FIX;
            end
            FIX: begin
                hi_d    = nr_q ? -rem_q : rem_q;
                lo_d    = nq_q ? -quo_q : quo_q;
                state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            qm1_q    <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MULTDIV_DIV_EN
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            nq_q     <= 1'b0;
            nr_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            qm1_q    <= qm1_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MULTDIV_DIV_EN
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            nq_q     <= nq_d;
            nr_q     <= nr_d;
`endif
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: per-cycle comparison against an arithmetic reference model,
// plus literal checks of the documented example operations. Honours MULTDIV_DIV_EN.
module tb_mult_div_unit;
    localparam int W = 32;
`ifdef MULTDIV_DIV_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    // Reference arithmetic: exact signed product, truncating signed division.
    function automatic int ref_lat(input logic o, input logic [W-1:0] y);
        if (!o) return W + 1;
        if (!EN || y == '0) return 1;
        return W + 2;
    endfunction

    function automatic logic ref_dz(input logic o, input logic [W-1:0] y);
        return o && (!EN || y == '0);
    endfunction

    function automatic logic [W-1:0] ref_hi(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o) begin
            p = sx * sy;
            return p[63:32];
        end
        if (y == '0) return '0;
        p = sx % sy;
        return p[31:0];
    endfunction

    function automatic logic [W-1:0] ref_lo(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o) begin
            p = sx * sy;
            return p[31:0];
        end
        if (y == '0) return '0;
        p = sx / sy;
        return p[31:0];
    endfunction

    // Transaction-level model: cycles since the accepted start, and the result it will publish.
    logic         m_active = 1'b0;
    int           m_cyc = 0;
    int           m_L = 0;
    logic         p_dz = 1'b0;
    logic [W-1:0] p_hi = '0, p_lo = '0, exp_hi = '0, exp_lo = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_cyc    <= 0;
            m_L      <= 0;
            p_dz     <= 1'b0;
            exp_hi   <= '0;
            exp_lo   <= '0;
        end else if (m_active && m_cyc == m_L) begin
            m_active <= 1'b0;
        end else if (m_active) begin
            m_cyc <= m_cyc + 1;
            if (m_cyc + 1 == m_L && !p_dz) begin
                exp_hi <= p_hi;
                exp_lo <= p_lo;
            end
        end else if (start) begin
            m_active <= 1'b1;
            m_cyc    <= 1;
            m_L      <= ref_lat(op, b);
            p_dz     <= ref_dz(op, b);
            p_hi     <= ref_hi(op, a, b);
            p_lo     <= ref_lo(op, a, b);
        end
    end

    logic e_busy, e_done, e_dz;
    always @(negedge clk) begin
        e_busy = m_active && (m_cyc < m_L);
        e_done = m_active && (m_cyc == m_L);
        e_dz   = e_done && p_dz;
        n_cmp++;
        if ({busy, done, div_zero, hi, lo} !== {e_busy, e_done, e_dz, exp_hi, exp_lo}) begin
            n_fail++;
            $display("FAIL cycle t=%0t busy/done/dz/hi/lo got %b %b %b %h %h expected %b %b %b %h %h",
                     $time, busy, done, div_zero, hi, lo, e_busy, e_done, e_dz, exp_hi, exp_lo);
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int pulse_at, output int lat, output int nbusy);
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 100) begin
            if (busy) nbusy++;
            if (lat == pulse_at) begin
                start = 1'b1;
                op    = 1'b0;
                a     = 32'd99;
                b     = 32'd77;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles", lat);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            5:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, nb, ndone;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_flags", {29'd0, busy, done, div_zero}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b0;

        issue(1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_done(-1, lat, nb);
        chk("mul7x-3_lat", 32'(lat), 32'd33);
        chk("mul7x-3_busy_cycles", 32'(nb), 32'd32);
        chk("mul7x-3_hi", hi, 32'hFFFF_FFFF);
        chk("mul7x-3_lo", lo, 32'hFFFF_FFEB);

        issue(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(-1, lat, nb);
        chk("mulmin_hi", hi, 32'h4000_0000);
        chk("mulmin_lo", lo, 32'h0000_0000);
        chk("mulmin_dz", {31'd0, div_zero}, 32'd0);

        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(-1, lat, nb);
        chk("div-7/2_lat", 32'(lat), EN ? 32'd34 : 32'd1);
        chk("div-7/2_busy_cycles", 32'(nb), EN ? 32'd33 : 32'd0);
        chk("div-7/2_lo", lo, EN ? 32'hFFFF_FFFD : 32'h0000_0000);
        chk("div-7/2_hi", hi, EN ? 32'hFFFF_FFFF : 32'h4000_0000);
        chk("div-7/2_dz", {31'd0, div_zero}, EN ? 32'd0 : 32'd1);

        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(-1, lat, nb);
        chk("divwrap_lo", lo, EN ? 32'h8000_0000 : 32'h0000_0000);
        chk("divwrap_hi", hi, EN ? 32'h0000_0000 : 32'h4000_0000);
        chk("divwrap_dz", {31'd0, div_zero}, EN ? 32'd0 : 32'd1);

        issue(1'b1, 32'd5, 32'd0);
        wait_done(-1, lat, nb);
        chk("div0_lat", 32'(lat), 32'd1);
        chk("div0_dz", {31'd0, div_zero}, 32'd1);
        chk("div0_busy_cycles", 32'(nb), 32'd0);
        chk("div0_hi", hi, EN ? 32'h0000_0000 : 32'h4000_0000);
        chk("div0_lo", lo, EN ? 32'h8000_0000 : 32'h0000_0000);

        issue(1'b1, 32'd10, 32'd3);
        wait_done(-1, lat, nb);
        chk("div10/3_lat", 32'(lat), EN ? 32'd34 : 32'd1);
        chk("div10/3_lo", lo, EN ? 32'd3 : 32'h0000_0000);
        chk("div10/3_hi", hi, EN ? 32'd1 : 32'h4000_0000);

        issue(1'b0, 32'd3, 32'd4);
        wait_done(5, lat, nb);
        chk("repulse_lat", 32'(lat), 32'd33);
        chk("repulse_lo", lo, 32'd12);
        chk("repulse_hi", hi, 32'd0);

        issue(1'b0, 32'd123456, 32'd789);
        repeat (9) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midreset_flags", {29'd0, busy, done, div_zero}, 32'd0);
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midreset_no_done", 32'(ndone), 32'd0);

        repeat (40) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'($urandom_range(0, 1)), pick(), pick());
            wait_done($urandom_range(1, 40), lat, nb);
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multicycle signed multiply/divide unit for the MIPS datapath. Takes operands from the A/B register outputs (rs/rt) and produces the 64-bit product, or the quotient and remainder, that the HI/LO registers load. The control unit drives it with a start/op request and stalls until `done` is seen. It implements `mult` and `div`; the `u` variants are out of scope.

## Interface
- `WIDTH`, default 32: operand width; the iteration counter is sized with `$clog2(WIDTH)+1` bits.

- `clk  in  1`: global clock, rising edge.
- `reset  in  1`: asynchronous, active-high reset.
- `start  in  1`: request strobe, sampled only while idle.
- `op  in  1`: operation; 0 = mult, 1 = div. Sampled with `start`.
- `a  in  WIDTH`: rs; multiplicand or dividend, two's complement.
- `b  in  WIDTH`: rt; multiplier or divisor, two's complement.
- `busy  out  1`: high while an operation is iterating.
- `done  out  1`: one-cycle pulse marking the cycle `hi`/`lo` first hold the new result.
- `hi  out  WIDTH`: product[2W-1:W] or remainder.
- `lo  out  WIDTH`: product[W-1:0] or quotient.
- `div_zero  out  1`: high in the `done` cycle of a div with `b == 0`; low otherwise.

## Operation
- FSM states: IDLE, MULT, DIV, FIX, DONE.
- Transitions:
  - IDLE with `start=1`, `op=0` → MULT.
  - IDLE with `start=1`, `op=1`, `b!=0` → DIV.
  - IDLE with `start=1`, `op=1`, `b==0` → DONE.
  - MULT → DONE after `WIDTH` iterations.
  - DIV → FIX after `WIDTH` iterations.
  - FIX → DONE.
  - DONE → IDLE.
- MULT: radix-2 Booth on a 2W+1-bit accumulator {P_hi, P_lo, q-1}.
  - Each iteration adds 0, +a or −a to P_hi per {q0, q-1}, then arithmetic-shifts right by 1.
  - Result is the exact signed 2W-bit product; no overflow is possible.
- DIV: restoring division on magnitudes |a| and |b|, one quotient bit per iteration.
- FIX (sign correction):
  - The quotient is negated when sign(a) ≠ sign(b).
  - The remainder takes the sign of a (truncation toward zero).
  - −2^(W−1) / −1 wraps: `lo` = 0x80000000, `hi` = 0. No flag is raised.
- Operands are captured at the start edge. Later changes to `a`, `b` or `op` have no effect on an operation in flight.
- `hi`/`lo` are written only on entry to DONE, and only by a successful operation. They hold their value between operations.
- Division by zero: `hi`/`lo` are unchanged and `div_zero=1` for the `done` cycle.
- `start` while not IDLE is ignored; it is neither queued nor does it restart the operation.

## Timing
- Cycle 0 is the cycle in which `start` is high in IDLE.
- Reset values: `busy=0`, `done=0`, `div_zero=0`, `hi=0`, `lo=0`; FSM in IDLE; all internal accumulators and counters cleared.
- `busy` is high in cycles 1..W for mult and 1..W+1 for div (includes FIX). It is low in the DONE cycle.
- `done` latency:
  - mult: `done` high in cycle W+1 (33 for W=32).
  - div: `done` high in cycle W+2 (34).
  - div by zero: `done` high in cycle 1; `busy` never asserts.
- `done` and the new `hi`/`lo` appear in the same cycle.
- A new `start` is accepted in the cycle after `done`, i.e. back in IDLE. Back-to-back issue is therefore one request per W+2 / W+3 cycles.
- `reset` asserted mid-operation:
  - Outputs clear immediately (asynchronously).
  - The operation is aborted and no `done` is produced.
  - After reset deasserts, the FSM sits in IDLE.

## Configuration
- `MULTDIV_DIV_EN` defined: the full divide path (DIV, FIX, restoring datapath, `div_zero`) is built, as described above.
- `MULTDIV_DIV_EN` undefined:
  - Divide hardware is omitted.
  - A `start` with `op=1` goes straight to DONE: `done` in cycle 1, `div_zero=1`, `hi`/`lo` unchanged.
  - Mult behaviour and timing are identical to the defined build.

## Test plan
- mult a=7, b=0xFFFFFFFD (−3) → `done` in cycle 33; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `busy` high in cycles 1..32.
- mult a=0x80000000, b=0x80000000 → `hi`=0x40000000, `lo`=0x00000000, `div_zero`=0.
- div a=0xFFFFFFF9 (−7), b=2 → `done` in cycle 34; `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1).
- div a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0. Then div a=5, b=0 → `done` in cycle 1, `div_zero`=1, `hi`/`lo` still 0/0x80000000.
- start mult 3×4, re-pulse `start` with different operands at cycle 5 → the re-pulse is ignored, `lo`=12 at cycle 33. Then start a mult and assert `reset` at cycle 10 → `hi`/`lo`/`busy` read 0 at once and no `done` follows.
- Built without `MULTDIV_DIV_EN`: div a=10, b=3 → `done` in cycle 1, `div_zero`=1, `hi`/`lo` unchanged. Mult 7×−3 still gives its result in cycle 33.
